rf_write_controller: RTL and testbench



---
 rtl/rf_ctrl_pkg.sv | 20 ++
 rtl/rf_wr_arbiter.sv | 42 ++++
 rtl/rf_write_controller.sv | 131 +++++++++++++
 tb/tb_rf_write_controller.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_ctrl_pkg.sv
// Shared types and defaults for the register-file write controller.
package rf_ctrl_pkg;

  // Controller phases: clearing the register file, then serving requesters
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ctrlState_t;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_REGS_DEF = 32;
  localparam int MAX_WAIT_DEF = 4;
  localparam logic [DATA_W_DEF-1:0] INIT_VALUE_DEF = '0;

  // Bit positions of each requester in the valid/grant vectors
  localparam int REQ_WB = 0;
  localparam int REQ_MC = 1;

endpackage

// File: rtl/rf_wr_arbiter.sv
// Two-way write-port arbiter: writeback wins by default, the multi-cycle unit
// wins once after MAX_WAIT consecutive lost arbitrations.
module rf_wr_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       clear,
  input  logic [1:0] valid,
  input  logic [1:0] accept,
  output logic [1:0] grant
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] starveCnt;
  logic             mcWins;

  // mc takes the port when alone or when it has been starved long enough
  always_comb begin
    mcWins = valid[REQ_MC] && (!valid[REQ_WB] || (starveCnt == CNT_MAX));
    grant = '0;
    grant[REQ_MC] = enable && mcWins;
    grant[REQ_WB] = enable && valid[REQ_WB] && !mcWins;
  end

  // Count wb wins that left a pending mc waiting; reset on mc win or restart
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starveCnt <= '0;
    end else if (clear || accept[REQ_MC]) begin
      starveCnt <= '0;
    end else if (accept[REQ_WB] && valid[REQ_MC] && (starveCnt != CNT_MAX)) begin
      starveCnt <= starveCnt + 1'b1;
    end
  end

endmodule

// File: rtl/rf_write_controller.sv
// Register-file write-port controller: clears every register after reset or
// on request, then shares the single write port between writeback and the
// multi-cycle unit. Optional macro RF_ZERO_REG_EN keeps register 0 constant
// in RUN by suppressing writes to address 0.
module rf_write_controller
  import rf_ctrl_pkg::*;
#(
  parameter int                DATA_W     = DATA_W_DEF,
  parameter int                ADDR_W     = ADDR_W_DEF,
  parameter int                NUM_REGS   = NUM_REGS_DEF,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0,
  parameter int                MAX_WAIT   = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_req,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              mc_valid,
  output logic              mc_ready,
  input  logic [ADDR_W-1:0] mc_addr,
  input  logic [DATA_W-1:0] mc_data,
  output logic              rf_write_enable,
  output logic [ADDR_W-1:0] rf_address_write,
  output logic [DATA_W-1:0] rf_data_write,
  output logic              init_done
);

  // One extra bit so the walk counter can reach NUM_REGS itself
  localparam logic [ADDR_W:0] WALK_END = (ADDR_W + 1)'(NUM_REGS);

  ctrlState_t        state;
  ctrlState_t        nextState;
  logic [ADDR_W:0]   initAddr;
  logic [1:0]        valids;
  logic [1:0]        grant;
  logic              arbEnable;
  logic              arbClear;
  logic              wrAccept;
  logic              writeAllowed;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selData;

  assign valids    = {mc_valid, wb_valid};
  assign arbEnable = (state == RUN) && !init_req;
  assign arbClear  = (state == RUN) && init_req;

  rf_wr_arbiter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_arbiter (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (arbEnable),
    .clear  (arbClear),
    .valid  (valids),
    .accept (grant),
    .grant  (grant)
  );

  assign wb_ready  = grant[REQ_WB];
  assign mc_ready  = grant[REQ_MC];
  assign init_done = (state == RUN);

  // Route the winning requester's address and data toward the write port
  always_comb begin
    wrAccept = |grant;
    selAddr  = wb_addr;
    selData  = wb_data;
    if (grant[REQ_MC]) begin
      selAddr = mc_addr;
      selData = mc_data;
    end
`ifdef RF_ZERO_REG_EN
    writeAllowed = (selAddr != '0);
`else
    writeAllowed = 1'b1;
`endif
  end

  // Next state: finish the walk into RUN, restart request back to INIT
  always_comb begin
    nextState = state;
    case (state)
      INIT:    if (initAddr == WALK_END) nextState = RUN;
      RUN:     if (init_req) nextState = INIT;
      default: nextState = INIT;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= INIT;
    else        state <= nextState;
  end

  // Walk counter and registered write-port outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      initAddr         <= '0;
      rf_write_enable  <= 1'b0;
      rf_address_write <= '0;
      rf_data_write    <= '0;
    end else begin
      case (state)
        INIT: begin
          if (initAddr < WALK_END) begin
            rf_write_enable  <= 1'b1;
            rf_address_write <= initAddr[ADDR_W-1:0];
            rf_data_write    <= INIT_VALUE;
            initAddr         <= initAddr + 1'b1;
          end else begin
            rf_write_enable <= 1'b0;
          end
        end
        default: begin
          if (wrAccept && writeAllowed) begin
            rf_write_enable  <= 1'b1;
            rf_address_write <= selAddr;
            rf_data_write    <= selData;
          end else begin
            rf_write_enable <= 1'b0;
          end
          if (init_req) initAddr <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_write_controller.sv
// Bench for rf_write_controller: init walk, arbitration table with a
// scoreboard of expected writes, restart and mid-walk reset sequences.
module tb_rf_write_controller;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NREGS = 32;
  localparam logic [DW-1:0] INITV = '0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          init_req = 1'b0;
  logic          wb_valid = 1'b0;
  logic          wb_ready;
  logic [AW-1:0] wb_addr = '0;
  logic [DW-1:0] wb_data = '0;
  logic          mc_valid = 1'b0;
  logic          mc_ready;
  logic [AW-1:0] mc_addr = '0;
  logic [DW-1:0] mc_data = '0;
  logic          rf_write_enable;
  logic [AW-1:0] rf_address_write;
  logic [DW-1:0] rf_data_write;
  logic          init_done;

  rf_write_controller dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .init_req         (init_req),
    .wb_valid         (wb_valid),
    .wb_ready         (wb_ready),
    .wb_addr          (wb_addr),
    .wb_data          (wb_data),
    .mc_valid         (mc_valid),
    .mc_ready         (mc_ready),
    .mc_addr          (mc_addr),
    .mc_data          (mc_data),
    .rf_write_enable  (rf_write_enable),
    .rf_address_write (rf_address_write),
    .rf_data_write    (rf_data_write),
    .init_done        (init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wbV;
    logic [AW-1:0] wbA;
    logic [DW-1:0] wbD;
    logic          mcV;
    logic [AW-1:0] mcA;
    logic [DW-1:0] mcD;
    logic          expWbRdy;
    logic          expMcRdy;
  } vec_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } expWr_t;

  vec_t   vecs[21];
  expWr_t sbQ[$];
  int     total = 0;
  int     bad = 0;
  logic [AW-1:0] lastAddr;
  logic [DW-1:0] lastData;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Starting just after an edge with the walk at address 0, check n walk writes
  task automatic walkSteps(input int n);
    for (int k = 0; k < n; k++) begin
      #1;
      chk("walk_readies", {wb_ready, mc_ready}, 2'b00);
      @(posedge clk); #1;
      chk("walk_write", {rf_write_enable, init_done, rf_address_write, rf_data_write},
          {1'b1, 1'b0, 5'(k), INITV});
    end
    $display("walk: %0d writes checked, last addr %0d", n, rf_address_write);
  endtask

  // The edge after the last walk write enters RUN with the port idle
  task automatic walkEnd();
    #1;
    chk("walk_end_readies", {wb_ready, mc_ready}, 2'b00);
    @(posedge clk); #1;
    chk("walk_end", {init_done, rf_write_enable}, 2'b10);
    $display("walk end: init_done=%0b we=%0b", init_done, rf_write_enable);
  endtask

  initial begin
    // wbV wbA wbD mcV mcA mcD expWb expMc
    vecs[0]  = '{1, 10, 5,  0, 0,  0,    1, 0};
    vecs[1]  = '{0, 0,  0,  0, 0,  0,    0, 0};
    vecs[2]  = '{0, 0,  0,  1, 3,  7,    0, 1};
    vecs[3]  = '{1, 1,  11, 1, 20, 99,   1, 0};
    vecs[4]  = '{1, 2,  12, 1, 20, 99,   1, 0};
    vecs[5]  = '{1, 4,  13, 1, 20, 99,   1, 0};
    vecs[6]  = '{1, 5,  14, 1, 20, 99,   1, 0};
    vecs[7]  = '{1, 6,  15, 1, 20, 99,   0, 1};
    vecs[8]  = '{1, 6,  15, 1, 20, 99,   1, 0};
    vecs[9]  = '{1, 7,  16, 1, 20, 99,   1, 0};
    vecs[10] = '{1, 8,  17, 1, 20, 99,   1, 0};
    vecs[11] = '{1, 9,  18, 1, 20, 99,   1, 0};
    vecs[12] = '{1, 12, 19, 1, 20, 99,   0, 1};
    vecs[13] = '{1, 13, 21, 0, 0,  0,    1, 0};
    vecs[14] = '{1, 14, 22, 1, 20, 99,   1, 0};
    vecs[15] = '{0, 0,  0,  0, 0,  0,    0, 0};
    vecs[16] = '{1, 15, 23, 1, 20, 99,   1, 0};
    vecs[17] = '{1, 16, 24, 1, 20, 99,   1, 0};
    vecs[18] = '{1, 17, 25, 1, 20, 99,   1, 0};
    vecs[19] = '{1, 18, 26, 1, 20, 99,   0, 1};
    vecs[20] = '{0, 0,  0,  1, 0,  'h55, 0, 1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {rf_write_enable, rf_address_write, rf_data_write, init_done, wb_ready, mc_ready},
        '0);
    $display("reset: we=%0b addr=%0d data=%0h done=%0b", rf_write_enable, rf_address_write,
             rf_data_write, init_done);
    @(posedge clk); #1;
    rst_n = 1'b1;
    walkSteps(NREGS);
    walkEnd();
    lastAddr = 5'(NREGS - 1);
    lastData = INITV;

    // Arbitration table with scoreboard of expected port writes
    for (int i = 0; i < 21; i++) begin
      expWr_t e;
      expWr_t got;
      wb_valid = vecs[i].wbV; wb_addr = vecs[i].wbA; wb_data = vecs[i].wbD;
      mc_valid = vecs[i].mcV; mc_addr = vecs[i].mcA; mc_data = vecs[i].mcD;
      #1;
      chk("readies", {wb_ready, mc_ready}, {vecs[i].expWbRdy, vecs[i].expMcRdy});
      chk("one_hot", 64'(wb_ready & mc_ready), 64'd0);
      e.we = 1'b0;
      if (vecs[i].expWbRdy) begin e.we = 1'b1; e.addr = vecs[i].wbA; e.data = vecs[i].wbD; end
      else if (vecs[i].expMcRdy) begin e.we = 1'b1; e.addr = vecs[i].mcA; e.data = vecs[i].mcD; end
`ifdef RF_ZERO_REG_EN
      if (e.we && e.addr == '0) e.we = 1'b0;
`endif
      if (e.we) begin lastAddr = e.addr; lastData = e.data; end
      else begin e.addr = lastAddr; e.data = lastData; end
      sbQ.push_back(e);
      @(posedge clk); #1;
      got = sbQ.pop_front();
      chk("rf_write", {rf_write_enable, rf_address_write, rf_data_write}, {got.we, got.addr, got.data});
      $display("vec %0d: wbR=%0b mcR=%0b -> we=%0b addr=%0d data=%0h", i, vecs[i].expWbRdy,
               vecs[i].expMcRdy, rf_write_enable, rf_address_write, rf_data_write);
    end
    mc_valid = 1'b0;

    // init_req with a pending writeback: blocked, walk repeats, then accepted
    wb_valid = 1'b1; wb_addr = 11; wb_data = 'h77; init_req = 1'b1;
    #1;
    chk("init_req_blocks", {wb_ready, mc_ready}, 2'b00);
    @(posedge clk); #1;
    chk("init_req_edge", {init_done, rf_write_enable}, 2'b00);
    $display("init_req: done=%0b we=%0b", init_done, rf_write_enable);
    init_req = 1'b0;
    walkSteps(NREGS);
    walkEnd();
    #1;
    chk("run_first_ready", {wb_ready, mc_ready}, 2'b10);
    @(posedge clk); #1;
    chk("run_first_write", {rf_write_enable, rf_address_write, rf_data_write}, {1'b1, 5'd11, 32'h77});
    $display("post-walk wb: we=%0b addr=%0d data=%0h", rf_write_enable, rf_address_write, rf_data_write);
    wb_valid = 1'b0;

    // Writeback to address 0 in RUN
    wb_valid = 1'b1; wb_addr = 0; wb_data = 'h1234;
    #1;
    chk("zero_ready", 64'(wb_ready), 64'd1);
    @(posedge clk); #1;
    wb_valid = 1'b0;
`ifdef RF_ZERO_REG_EN
    chk("zero_write", 64'(rf_write_enable), 64'd0);
`else
    chk("zero_write", {rf_write_enable, rf_address_write, rf_data_write}, {1'b1, 5'd0, 32'h1234});
`endif
    $display("zero addr: we=%0b addr=%0d data=%0h", rf_write_enable, rf_address_write, rf_data_write);

    // Reset asserted mid-walk at address 17
    init_req = 1'b1;
    @(posedge clk); #1;
    init_req = 1'b0;
    walkSteps(18);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midwalk_reset", {rf_write_enable, rf_address_write, rf_data_write, init_done}, '0);
    $display("mid-walk reset: we=%0b addr=%0d", rf_write_enable, rf_address_write);
    @(posedge clk); #1;
    rst_n = 1'b1;
    walkSteps(NREGS);
    walkEnd();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the bench always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
